pd_sched: RTL and testbench
===========================

PD_SCHED -- requirements
Module: pd_sched

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 16, bytes serialized per frame (legal 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, width of match counter.
REQ-003 clk_i  input  1  single clock, all logic on rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  start a frame; honoured only in IDLE.
REQ-006 abort_i  input  1  abandon current frame.
REQ-007 in_data_i  input  8  byte to serialize.
REQ-008 in_valid_i  input  1  in_data_i valid.
REQ-009 in_ready_o  output  1  block accepts a byte this cycle.
REQ-010 det_rst_o  output  1  active-high reset to the 110110 Moore pattern detector.
REQ-011 det_data_o  output  1  serial bit to detector.
REQ-012 det_valid_o  output  1  det_data_o valid.
REQ-013 det_pd_i  input  1  detector pattern-detect output.
REQ-014 busy_o  output  1  high in every state except IDLE.
REQ-015 done_o  output  1  one-cycle frame-complete pulse.
REQ-016 match_cnt_o  output  CNT_W  matches counted in last or current frame.

Function
REQ-017 FSM states SHALL be IDLE, CLR, WAIT, SHIFT, DRAIN, DONE.
REQ-018 IDLE: start_i=1 -> CLR; otherwise stay; all handshake outputs low.
REQ-019 CLR: det_rst_o=1 for exactly one cycle, match counter and byte counter cleared, -> WAIT.
REQ-020 WAIT: in_ready_o=1; on in_valid_i&&in_ready_o load byte into shift register, bit counter=7, -> SHIFT; no valid -> stay, det_valid_o=0.
REQ-021 SHIFT: det_valid_o=1, det_data_o=shift register MSB, shift left each cycle, 8 cycles per byte.
REQ-022 After 8th bit: byte counter==FRAME_BYTES-1 -> DRAIN, else byte counter+1 -> WAIT; throughput 9 cycles/byte minimum.
REQ-023 DRAIN: one cycle, det_valid_o=0, exists only to sample det_pd_i following the final bit; -> DONE.
REQ-024 DONE: done_o=1 for one cycle, -> IDLE; match_cnt_o held until next CLR.
REQ-025 Match counting: counter SHALL increment when det_pd_i=1 in a cycle whose previous cycle had det_valid_o=1 (one-cycle qualifier flop); det_pd_i ignored otherwise.
REQ-026 Overlapping matches SHALL each count (detector handles overlap; block counts qualified pulses).
REQ-027 start_i outside IDLE SHALL be ignored.
REQ-028 abort_i=1 in any non-IDLE state SHALL force IDLE next cycle, no done_o, det_valid_o and in_ready_o low from next cycle, match_cnt_o keeps partial value; abort_i has priority over all other transitions.
REQ-029 A byte SHALL never be accepted outside WAIT; in_valid_i with in_ready_o=0 has no effect.

Reset
REQ-030 rst_ni low SHALL immediately force IDLE, clear shift register, bit/byte counters, qualifier flop, match_cnt_o=0.
REQ-031 During reset: in_ready_o=0, det_valid_o=0, det_data_o=0, busy_o=0, done_o=0, det_rst_o=1.
REQ-032 Reset mid-frame SHALL discard the frame without done_o; after release block waits for start_i.

Configuration
REQ-033 Macro PD_SCHED_SAT_EN defined: match counter SHALL saturate at 2^CNT_W-1.
REQ-034 PD_SCHED_SAT_EN undefined: match counter SHALL wrap modulo 2^CNT_W.

Verification
REQ-035 FRAME_BYTES=2, start, bytes 0xDB,0x6D (bits 1101101101101101) -> 16 det_valid_o cycles, done_o one cycle, match_cnt_o=4.
REQ-036 FRAME_BYTES=2, bytes 0x00,0x00 -> done_o, match_cnt_o=0; det_rst_o pulsed once after start.
REQ-037 CNT_W=2, bytes 0xDB,0x6D -> match_cnt_o=3 with PD_SCHED_SAT_EN, 0 without.
REQ-038 in_valid_i withheld 5 cycles in WAIT -> in_ready_o high throughout, det_valid_o low, count unchanged, frame then completes normally.
REQ-039 abort_i during 4th SHIFT cycle of byte 1 -> busy_o low next cycle, no done_o, det_valid_o low; start_i during SHIFT ignored.
REQ-040 rst_ni low mid-SHIFT -> outputs at reset values immediately; new start after release yields correct count.

Source files
------------

// File: rtl/pd_sched.sv
// pd_sched: byte-to-bit serializer that drives an external 110110 Moore pattern
// detector and counts its qualified match pulses over one frame.
// Optional build macro PD_SCHED_SAT_EN: the match counter saturates at its
// maximum value instead of wrapping modulo 2^CNT_W.
module pd_sched #(
    parameter int FRAME_BYTES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [7:0]       in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             det_rst_o,
    output logic             det_data_o,
    output logic             det_valid_o,
    input  logic             det_pd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_WAIT,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       byte_cnt_q, byte_cnt_d;
    logic             qual_q, qual_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

    // Moore outputs decoded from the state register; the detector is also
    // held in reset while the block itself is in reset.
    assign in_ready_o  = (state_q == S_WAIT);
    assign det_valid_o = (state_q == S_SHIFT);
    assign det_data_o  = (state_q == S_SHIFT) & shift_q[7];
    assign det_rst_o   = (state_q == S_CLR) | ~rst_ni;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign match_cnt_o = match_cnt_q;

    // Next-state, shift register and byte/bit counters; abort overrides all.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_CLR;
            end
            S_CLR: begin
                byte_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (in_valid_i) begin
                    shift_d   = in_data_i;
                    bit_cnt_d = 3'd7;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d = {shift_q[6:0], 1'b0};
                if (bit_cnt_q == 3'd0) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = S_DRAIN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        state_d    = S_WAIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    // Match counting: a detect pulse counts only if a bit was presented in
    // the previous cycle, so a held Moore output is never counted twice.
    always_comb begin
        qual_d      = det_valid_o;
        match_cnt_d = match_cnt_q;
        if (state_q == S_CLR) begin
            match_cnt_d = '0;
        end else if (qual_q && det_pd_i) begin
`ifdef PD_SCHED_SAT_EN
            if (match_cnt_q != {CNT_W{1'b1}}) match_cnt_d = match_cnt_q + 1'b1;
`else
            match_cnt_d = match_cnt_q + 1'b1;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            qual_q      <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            qual_q      <= qual_d;
            match_cnt_q <= match_cnt_d;
        end
    end

endmodule

// File: tb/tb_pd_sched.sv
// tb_pd_sched: two pd_sched instances (8-bit and 2-bit match counters) share
// stimulus and a behavioural 110110 Moore detector; expected counts come from
// scanning the frame's bit stream for the pattern.
module tb_pd_sched;

    localparam int FB = 2;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, in_valid;
    logic [7:0] in_data;
    logic       in_ready, det_rst, det_data, det_valid, busy, done;
    logic [7:0] cnt0;
    logic       in_ready1, det_rst1, det_data1, det_valid1, busy1, done1;
    logic [1:0] cnt1;
    logic [5:0] hist = '0;
    logic       det_pd;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] fb [FB];
    int         gp [FB];
    bit         stream [$];

    always #5 clk = ~clk;

    pd_sched #(.FRAME_BYTES(FB), .CNT_W(8)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .det_rst_o(det_rst), .det_data_o(det_data), .det_valid_o(det_valid),
        .det_pd_i(det_pd), .busy_o(busy), .done_o(done), .match_cnt_o(cnt0)
    );

    pd_sched #(.FRAME_BYTES(FB), .CNT_W(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .det_rst_o(det_rst1), .det_data_o(det_data1), .det_valid_o(det_valid1),
        .det_pd_i(det_pd), .busy_o(busy1), .done_o(done1), .match_cnt_o(cnt1)
    );

    // Behavioural Moore detector: output reflects the last six accepted bits.
    always @(posedge clk) begin
        if (det_rst) hist <= '0;
        else if (det_valid) hist <= {hist[4:0], det_data};
    end
    assign det_pd = (hist == 6'b110110);

    // Number of 110110 occurrences (overlaps included) in the first n bits.
    function automatic int m(input int n);
        int c = 0;
        logic [5:0] w;
        for (int k = 5; k < n; k++) begin
            w = '0;
            for (int j = 0; j < 6; j++) w = {w[4:0], stream[k - 5 + j]};
            if (w == 6'b110110) c++;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int n);
        int mc;
        int m2;
        mc = m(n);
`ifdef PD_SCHED_SAT_EN
        m2 = (mc > 3) ? 3 : mc;
`else
        m2 = mc % 4;
`endif
        chk({tag, "_cnt8"}, 32'(cnt0), 32'(mc % 256));
        chk({tag, "_cnt2"}, 32'(cnt1), 32'(m2));
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one frame from IDLE using fb[]/gp[]; abort at (ab_byte, ab_bit)
    // when ab_byte >= 0. Called and returns at a falling edge.
    task automatic run_frame(input int ab_byte, input int ab_bit);
        int ex;
        stream.delete();
        for (int b = 0; b < FB; b++)
            for (int i = 0; i < 8; i++) stream.push_back(fb[b][7 - i]);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("clr_det_rst", 32'(det_rst), 1);
        chk("clr_det_rst1", 32'(det_rst1), 1);
        chk("clr_busy", 32'(busy), 1);
        chk("clr_ready", 32'(in_ready), 0);
        cyc();
        for (int b = 0; b < FB; b++) begin
            for (int g = 0; g <= gp[b]; g++) begin
                start    = 1'b0;
                in_valid = (g == gp[b]);
                in_data  = (g == gp[b]) ? fb[b] : 8'($urandom);
                chk("wait_ready", 32'(in_ready), 1);
                chk("wait_ready1", 32'(in_ready1), 1);
                chk("wait_dvalid", 32'(det_valid), 0);
                chk("wait_det_rst", 32'(det_rst), 0);
                chk("wait_busy", 32'(busy), 1);
                ex = (b > 0 && g == 0) ? 8 * b - 1 : 8 * b;
                chk_cnt("wait", ex);
                cyc();
            end
            in_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                start    = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                chk("shift_dvalid", 32'(det_valid), 1);
                chk("shift_dvalid1", 32'(det_valid1), 1);
                chk("shift_data", 32'(det_data), 32'(stream[8 * b + i]));
                chk("shift_data1", 32'(det_data1), 32'(stream[8 * b + i]));
                chk("shift_ready", 32'(in_ready), 0);
                chk("shift_done", 32'(done), 0);
                chk_cnt("shift", 8 * b + ((i > 0) ? i - 1 : 0));
                if (b == ab_byte && i == ab_bit) begin
                    abort = 1'b1;
                    cyc();
                    abort    = 1'b0;
                    start    = 1'b0;
                    in_valid = 1'b0;
                    chk("abort_busy", 32'(busy), 0);
                    chk("abort_busy1", 32'(busy1), 0);
                    chk("abort_dvalid", 32'(det_valid), 0);
                    chk("abort_ready", 32'(in_ready), 0);
                    chk("abort_done", 32'(done), 0);
                    cyc();
                    chk("abort_done2", 32'(done), 0);
                    chk("abort_busy2", 32'(busy), 0);
                    chk_cnt("abort", 8 * b + i + 1);
                    return;
                end
                cyc();
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("drain_dvalid", 32'(det_valid), 0);
        chk("drain_busy", 32'(busy), 1);
        chk("drain_done", 32'(done), 0);
        chk("drain_ready", 32'(in_ready), 0);
        chk_cnt("drain", 8 * FB - 1);
        cyc();
        chk("done_pulse", 32'(done), 1);
        chk("done_pulse1", 32'(done1), 1);
        chk("done_busy", 32'(busy), 1);
        chk_cnt("done", 8 * FB);
        cyc();
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_det_rst", 32'(det_rst), 0);
        chk_cnt("idle_hold", 8 * FB);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_dvalid", 32'(det_valid), 0);
        chk("rst_ddata", 32'(det_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_det_rst", 32'(det_rst), 1);
        chk("rst_cnt8", 32'(cnt0), 0);
        chk("rst_cnt2", 32'(cnt1), 0);
        rst_n = 1'b1;
        cyc();
        chk("idle_after_rst_busy", 32'(busy), 0);
        chk("idle_after_rst_det_rst", 32'(det_rst), 0);

        // 0xDB,0x6D back to back: four overlapping matches
        fb[0] = 8'hDB; fb[1] = 8'h6D; gp[0] = 0; gp[1] = 0;
        run_frame(-1, 0);
        // all zeros: no matches
        fb[0] = 8'h00; fb[1] = 8'h00;
        run_frame(-1, 0);
        // input withheld five cycles in WAIT before each byte
        fb[0] = 8'hDB; fb[1] = 8'h6D; gp[0] = 5; gp[1] = 5;
        run_frame(-1, 0);
        // abort in the fourth shift cycle of the second byte
        gp[0] = 1; gp[1] = 0;
        run_frame(1, 3);

        // reset asserted mid-shift
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        in_valid = 1'b1;
        in_data  = 8'hB6;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 0);
        chk("mid_rst_dvalid", 32'(det_valid), 0);
        chk("mid_rst_ddata", 32'(det_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_det_rst", 32'(det_rst), 1);
        chk("mid_rst_cnt8", 32'(cnt0), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        cyc();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        cyc();
        fb[0] = 8'hDB; fb[1] = 8'h6D; gp[0] = 0; gp[1] = 2;
        run_frame(-1, 0);

        // randomized frames, biased toward pattern-rich bytes
        for (int f = 0; f < 24; f++) begin
            int ab_b;
            int ab_i;
            for (int b = 0; b < FB; b++) begin
                case ($urandom_range(0, 3))
                    0:       fb[b] = 8'hDB;
                    1:       fb[b] = 8'h6D;
                    2:       fb[b] = 8'hB6;
                    default: fb[b] = 8'($urandom);
                endcase
                gp[b] = int'($urandom_range(0, 3));
            end
            ab_b = -1;
            ab_i = 0;
            if ($urandom_range(0, 3) == 0) begin
                ab_b = int'($urandom_range(0, FB - 1));
                ab_i = int'($urandom_range(0, 7));
            end
            run_frame(ab_b, ab_i);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
